force_accumulator: RTL and testbench

- Consumer end of the per-node force stream emitted by the force producers (torque, spring, collision).
- Each producer stream is one valid beat per node, node 0 first, then a one-cycle done pulse.
- The block sums the beats into per-node X/Y force accumulators over one physics frame.
- On `apply_in` it integrates the accumulated forces into per-node velocities, one node per cycle, clears the accumulators and pulses `apply_done_out`.

---
 rtl/physics_pkg.sv | 30 +++
 rtl/force_accumulator_sat_add.sv | 23 ++
 rtl/force_accumulator.sv | 152 +++++++++++++++
 tb/tb_force_accumulator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/physics_pkg.sv
// Shared types, default widths and the saturating clamp used by the physics
// datapath blocks.
package physics_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        APPLY,
        DONE
    } force_acc_state_t;

    localparam int DEFAULT_FORCE_SIZE = 8;
    localparam int DEFAULT_ACC_SIZE   = 12;
    localparam int DEFAULT_VEL_SIZE   = 8;

    // Clamp a wide signed value into the range of a width-bit signed number.
    function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] value,
                                                     input int unsigned width);
        logic signed [31:0] max_v;
        logic signed [31:0] min_v;
        max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
        min_v = -(32'sd1 <<< (width - 1));
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/force_accumulator_sat_add.sv
// sat_add: signed adder whose result saturates to the OUT_SIZE range.
module sat_add
    import physics_pkg::*;
#(
    parameter int A_SIZE   = 12,
    parameter int B_SIZE   = 8,
    parameter int OUT_SIZE = 12
) (
    input  logic signed [A_SIZE-1:0]   a,
    input  logic signed [B_SIZE-1:0]   b,
    output logic signed [OUT_SIZE-1:0] sum
);

    logic signed [31:0] full_sum;
    logic signed [31:0] clamped;

    always_comb begin
        full_sum = 32'(a) + 32'(b);
        clamped  = sat_clamp(full_sum, OUT_SIZE);
        sum      = OUT_SIZE'(clamped);
    end

endmodule

// File: rtl/force_accumulator.sv
// force_accumulator: sums per-node force beats over a frame, then integrates
// them into velocities one node per cycle. Optional damping: FORCE_ACCUM_DAMPING_EN.
module force_accumulator
    import physics_pkg::*;
#(
    parameter int NUM_NODES   = 10,
    parameter int FORCE_SIZE  = DEFAULT_FORCE_SIZE,
    parameter int ACC_SIZE    = DEFAULT_ACC_SIZE,
    parameter int VEL_SIZE    = DEFAULT_VEL_SIZE,
    parameter int FORCE_SHIFT = 2
`ifdef FORCE_ACCUM_DAMPING_EN
    ,
    parameter int DAMP_SHIFT  = 3
`endif
) (
    input  logic                                         clk_in,
    input  logic                                         rst_in,
    input  logic signed [FORCE_SIZE-1:0]                 force_x_in,
    input  logic signed [FORCE_SIZE-1:0]                 force_y_in,
    input  logic                                         force_in_valid,
    input  logic                                         source_done_in,
    input  logic                                         apply_in,
    output logic signed [1:0][NUM_NODES-1:0][VEL_SIZE-1:0] vel_out,
    output logic                                         busy_out,
    output logic                                         apply_done_out,
    output logic                                         err_out
);

    localparam int IDX_SIZE = $clog2(NUM_NODES + 1);
    localparam logic [IDX_SIZE-1:0] LAST_NODE = IDX_SIZE'(NUM_NODES - 1);
    localparam logic [IDX_SIZE-1:0] END_IDX   = IDX_SIZE'(NUM_NODES);

    force_acc_state_t state;
    force_acc_state_t next_state;

    logic [IDX_SIZE-1:0] idx;
    logic [IDX_SIZE-1:0] sweep_idx;
    logic [IDX_SIZE-1:0] beat_node;
    logic                beat_ok;

    logic signed [ACC_SIZE-1:0] acc_x [NUM_NODES];
    logic signed [ACC_SIZE-1:0] acc_y [NUM_NODES];
    logic signed [ACC_SIZE-1:0] acc_x_next;
    logic signed [ACC_SIZE-1:0] acc_y_next;
    logic signed [ACC_SIZE-1:0] acc_x_shifted;
    logic signed [ACC_SIZE-1:0] acc_y_shifted;

    logic signed [VEL_SIZE-1:0] vel_x_cur;
    logic signed [VEL_SIZE-1:0] vel_y_cur;
    logic signed [VEL_SIZE-1:0] vel_x_base;
    logic signed [VEL_SIZE-1:0] vel_y_base;
    logic signed [VEL_SIZE-1:0] vel_x_next;
    logic signed [VEL_SIZE-1:0] vel_y_next;

    // Beats past the last node are dropped; keep the read index in range anyway.
    assign beat_ok   = idx < END_IDX;
    assign beat_node = beat_ok ? idx : '0;

    sat_add #(.A_SIZE(ACC_SIZE), .B_SIZE(FORCE_SIZE), .OUT_SIZE(ACC_SIZE)) u_acc_x (
        .a(acc_x[beat_node]), .b(force_x_in), .sum(acc_x_next)
    );
    sat_add #(.A_SIZE(ACC_SIZE), .B_SIZE(FORCE_SIZE), .OUT_SIZE(ACC_SIZE)) u_acc_y (
        .a(acc_y[beat_node]), .b(force_y_in), .sum(acc_y_next)
    );

    assign acc_x_shifted = acc_x[sweep_idx] >>> FORCE_SHIFT;
    assign acc_y_shifted = acc_y[sweep_idx] >>> FORCE_SHIFT;
    assign vel_x_cur     = vel_out[0][sweep_idx];
    assign vel_y_cur     = vel_out[1][sweep_idx];

`ifdef FORCE_ACCUM_DAMPING_EN
    // v - (v >>> k) shrinks the magnitude, so it can never overflow.
    assign vel_x_base = vel_x_cur - (vel_x_cur >>> DAMP_SHIFT);
    assign vel_y_base = vel_y_cur - (vel_y_cur >>> DAMP_SHIFT);
`else
    assign vel_x_base = vel_x_cur;
    assign vel_y_base = vel_y_cur;
`endif

    sat_add #(.A_SIZE(VEL_SIZE), .B_SIZE(ACC_SIZE), .OUT_SIZE(VEL_SIZE)) u_vel_x (
        .a(vel_x_base), .b(acc_x_shifted), .sum(vel_x_next)
    );
    sat_add #(.A_SIZE(VEL_SIZE), .B_SIZE(ACC_SIZE), .OUT_SIZE(VEL_SIZE)) u_vel_y (
        .a(vel_y_base), .b(acc_y_shifted), .sum(vel_y_next)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ACCUM:   if (apply_in) next_state = APPLY;
            APPLY:   if (sweep_idx == LAST_NODE) next_state = DONE;
            DONE:    next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
    end

    always_comb begin
        busy_out       = (state == APPLY);
        apply_done_out = (state == DONE);
    end

    // The sweep index wraps to 0 after the last node so it never addresses past the arrays.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idx       <= '0;
            sweep_idx <= '0;
            err_out   <= 1'b0;
            vel_out   <= '0;
            for (int n = 0; n < NUM_NODES; n++) begin
                acc_x[n] <= '0;
                acc_y[n] <= '0;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (force_in_valid) begin
                        if (beat_ok) begin
                            acc_x[beat_node] <= acc_x_next;
                            acc_y[beat_node] <= acc_y_next;
                            idx              <= idx + IDX_SIZE'(1);
                        end else begin
                            err_out <= 1'b1;
                        end
                    end
                    if (source_done_in) idx <= '0;
                    if (apply_in) sweep_idx <= '0;
                end
                APPLY: begin
                    vel_out[0][sweep_idx] <= vel_x_next;
                    vel_out[1][sweep_idx] <= vel_y_next;
                    acc_x[sweep_idx]      <= '0;
                    acc_y[sweep_idx]      <= '0;
                    sweep_idx <= (sweep_idx == LAST_NODE) ? '0 : sweep_idx + IDX_SIZE'(1);
                    if (force_in_valid) err_out <= 1'b1;
                end
                DONE: begin
                    idx <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_force_accumulator.sv
// tb_force_accumulator: table-driven stream/apply vectors plus hand-written
// sequences for protocol errors, coincident inputs and reset mid-sweep.
module tb_force_accumulator;

    localparam int NUM_NODES  = 10;
    localparam int FORCE_SIZE = 8;
    localparam int VEL_SIZE   = 8;

    logic                                           clk_in = 1'b0;
    logic                                           rst_in;
    logic signed [FORCE_SIZE-1:0]                   force_x_in;
    logic signed [FORCE_SIZE-1:0]                   force_y_in;
    logic                                           force_in_valid;
    logic                                           source_done_in;
    logic                                           apply_in;
    logic signed [1:0][NUM_NODES-1:0][VEL_SIZE-1:0] vel_out;
    logic                                           busy_out;
    logic                                           apply_done_out;
    logic                                           err_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int fx;
        int fy;
        int beats;
        int streams;
        int exp_vx;
        int exp_vy;
    } vec_t;

    vec_t vectors[6];

    force_accumulator dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .force_x_in(force_x_in),
        .force_y_in(force_y_in),
        .force_in_valid(force_in_valid),
        .source_done_in(source_done_in),
        .apply_in(apply_in),
        .vel_out(vel_out),
        .busy_out(busy_out),
        .apply_done_out(apply_done_out),
        .err_out(err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    function automatic int vel(input int axis, input int node);
        logic signed [VEL_SIZE-1:0] v;
        v = vel_out[axis][node];
        return int'(v);
    endfunction

    task automatic do_reset();
        rst_in         = 1'b1;
        force_in_valid = 1'b0;
        source_done_in = 1'b0;
        apply_in       = 1'b0;
        force_x_in     = '0;
        force_y_in     = '0;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic send_beat(input int x, input int y);
        force_in_valid = 1'b1;
        force_x_in     = FORCE_SIZE'(x);
        force_y_in     = FORCE_SIZE'(y);
        tick();
        force_in_valid = 1'b0;
    endtask

    task automatic send_done();
        source_done_in = 1'b1;
        tick();
        source_done_in = 1'b0;
    endtask

    task automatic apply_stimulus(input int x, input int y, input int beats);
        for (int b = 0; b < beats; b++) send_beat(x, y);
        send_done();
    endtask

    // Pulse apply_in (any beat already set up rides along), then time the sweep.
    task automatic apply_sweep(input string name);
        int busy_cycles;
        bit seen;
        busy_cycles = 0;
        seen        = 1'b0;
        apply_in    = 1'b1;
        tick();
        apply_in       = 1'b0;
        force_in_valid = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            if (apply_done_out) seen = 1'b1;
            else begin
                if (busy_out) busy_cycles++;
                tick();
            end
        end
        check_output({name, "_done_seen"}, int'(seen), 1);
        check_output({name, "_busy_cycles"}, busy_cycles, NUM_NODES);
        check_output({name, "_busy_in_done"}, int'(busy_out), 0);
        tick();
        check_output({name, "_done_width"}, int'(apply_done_out), 0);
    endtask

    task automatic check_vel_all(input string name, input int ex, input int ey);
        for (int n = 0; n < NUM_NODES; n++) begin
            check_output($sformatf("%s_vx%0d", name, n), vel(0, n), ex);
            check_output($sformatf("%s_vy%0d", name, n), vel(1, n), ey);
        end
    endtask

    initial begin
        int pulses;
        bit seen;

        vectors[0] = '{fx: 8,    fy: -4, beats: 10, streams: 1,  exp_vx: 2,    exp_vy: -1};
        vectors[1] = '{fx: 100,  fy: 0,  beats: 10, streams: 2,  exp_vx: 50,   exp_vy: 0};
        vectors[2] = '{fx: 127,  fy: 0,  beats: 10, streams: 20, exp_vx: 127,  exp_vy: 0};
        vectors[3] = '{fx: -128, fy: 0,  beats: 10, streams: 20, exp_vx: -128, exp_vy: 0};
        vectors[4] = '{fx: -5,   fy: 3,  beats: 10, streams: 1,  exp_vx: -2,   exp_vy: 0};
        vectors[5] = '{fx: 1,    fy: -1, beats: 10, streams: 4,  exp_vx: 1,    exp_vy: -1};

        // Reset state
        do_reset();
        check_vel_all("reset", 0, 0);
        check_output("reset_busy", int'(busy_out), 0);
        check_output("reset_done", int'(apply_done_out), 0);
        check_output("reset_err", int'(err_out), 0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            for (int s = 0; s < vectors[i].streams; s++)
                apply_stimulus(vectors[i].fx, vectors[i].fy, vectors[i].beats);
            apply_sweep($sformatf("vec%0d", i));
            check_vel_all($sformatf("vec%0d", i), vectors[i].exp_vx, vectors[i].exp_vy);
            check_output($sformatf("vec%0d_err", i), int'(err_out), 0);
        end

        // Second apply with no new beats leaves velocities unchanged
        do_reset();
        apply_stimulus(8, -4, 10);
        apply_sweep("basic");
        apply_sweep("reapply");
        check_vel_all("reapply", 2, -1);

        // Node 3 gets y=-7 in only one of two streams
        do_reset();
        for (int n = 0; n < NUM_NODES; n++) send_beat(100, (n == 3) ? -7 : 0);
        send_done();
        apply_stimulus(100, 0, 10);
        apply_sweep("node3");
        for (int n = 0; n < NUM_NODES; n++) begin
            check_output($sformatf("node3_vx%0d", n), vel(0, n), 50);
            check_output($sformatf("node3_vy%0d", n), vel(1, n), (n == 3) ? -2 : 0);
        end

        // 11 beats: the extra one is dropped and flags an error
        do_reset();
        apply_stimulus(4, 4, 11);
        check_output("overrun_err", int'(err_out), 1);
        apply_sweep("overrun");
        check_vel_all("overrun", 1, 1);
        check_output("overrun_err_sticky", int'(err_out), 1);

        // Short stream, and a beat coinciding with done
        do_reset();
        send_beat(4, 0);
        send_beat(4, 0);
        source_done_in = 1'b1;
        send_beat(4, 0);
        source_done_in = 1'b0;
        apply_stimulus(4, 0, 1);
        apply_sweep("short");
        for (int n = 0; n < NUM_NODES; n++)
            check_output($sformatf("short_vx%0d", n), vel(0, n), (n == 0) ? 2 : (n < 3) ? 1 : 0);
        check_output("short_err", int'(err_out), 0);

        // Beat in the same cycle as apply_in is still integrated; DONE rewinds the index
        do_reset();
        for (int b = 0; b < NUM_NODES - 1; b++) send_beat(8, -4);
        force_in_valid = 1'b1;
        force_x_in     = 8'sd8;
        force_y_in     = -8'sd4;
        apply_sweep("coincide");
        check_vel_all("coincide", 2, -1);
        for (int b = 0; b < NUM_NODES; b++) send_beat(8, 0);
        check_output("coincide_err", int'(err_out), 0);
        apply_sweep("coincide2");
        check_vel_all("coincide2", 4, -1);

        // Beats during APPLY are ignored but flag an error
        do_reset();
        apply_stimulus(8, -4, 10);
        apply_in = 1'b1;
        tick();
        apply_in = 1'b0;
        for (int c = 0; c < 3; c++) send_beat(100, 100);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (apply_done_out) seen = 1'b1;
            else tick();
        end
        check_output("applybeat_done_seen", int'(seen), 1);
        tick();
        check_output("applybeat_err", int'(err_out), 1);
        check_vel_all("applybeat", 2, -1);
        apply_sweep("applybeat2");
        check_vel_all("applybeat2", 2, -1);

        // Reset at sweep node 4 clears everything and suppresses apply_done_out
        do_reset();
        apply_stimulus(8, -4, 10);
        apply_in = 1'b1;
        tick();
        apply_in = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check_output("midreset_busy_before", int'(busy_out), 1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check_vel_all("midreset", 0, 0);
        check_output("midreset_busy", int'(busy_out), 0);
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            if (apply_done_out) pulses++;
            tick();
        end
        check_output("midreset_no_done", pulses, 0);
        apply_sweep("midreset_apply");
        check_vel_all("midreset_acc", 0, 0);
        check_output("midreset_err", int'(err_out), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
